led_rate_meas: RTL and testbench

Measures the blink rate of an LED-style square wave and reports it as a 12-bit tick count. It is the read-back counterpart of the LED divider path: it sits on the `clk100` domain next to the LED counter, takes the LED drive (or an external pin), and returns period and high-time values. Results go to the register/debug interface through a valid/ack handshake.

---
 rtl/led_pkg.sv | 15 +
 rtl/led_rate_meas_if.sv | 14 +
 rtl/led_edge_sync.sv | 34 +++
 rtl/led_rate_meas.sv | 115 +++++++++++
 tb/tb_led_rate_meas.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED rate measurement path.
// The saturation helper matches the LED divider counter width.
package led_pkg;

  typedef enum logic [0:0] {SYNC, MEAS} meas_state_t;

  localparam int unsigned CNT_W_DEFAULT = 12;

  function automatic int unsigned sat_val(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned SAT_DEFAULT = sat_val(CNT_W_DEFAULT);

endpackage

// File: rtl/led_rate_meas_if.sv
// Result/handshake bundle between the rate meter and the register/debug consumer.
interface led_rate_meas_if #(
  parameter int unsigned CNT_W = led_pkg::CNT_W_DEFAULT
) ();
  logic             ack_i;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             lost_o;
  logic             stall_o;

  modport master (input ack_i, output period_o, high_o, valid_o, lost_o, stall_o);
  modport slave  (output ack_i, input period_o, high_o, valid_o, lost_o, stall_o);
endinterface

// File: rtl/led_edge_sync.sv
// Two-flop synchronizer plus edge-detect register for asynchronous pin inputs.
// lvl_o is delayed to line up with the registered rise/fall strobes.
module led_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, d_q, rise_q, fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      d_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      d_q    <= s2_q;
      rise_q <= s2_q & ~d_q;
      fall_q <= ~s2_q & d_q;
    end
  end

  assign lvl_o  = d_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/led_rate_meas.sv
// Measures period and high time of an LED square wave in prescaled ticks and
// hands the result to a consumer through a valid/ack handshake.
module led_rate_meas
  import led_pkg::*;
#(
  parameter int unsigned PRESCALE = 100,
  parameter int unsigned CNT_W    = led_pkg::CNT_W_DEFAULT
) (
  input  logic            clk100,
  input  logic            rst,
  input  logic            led_i,
  led_rate_meas_if.master res
);

  localparam logic [CNT_W-1:0] SAT     = CNT_W'(sat_val(CNT_W));
  localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);

  logic lvl, rise, fall, unused_fall;

  led_edge_sync u_sync (
    .clk    (clk100),
    .rst    (rst),
    .din    (led_i),
    .lvl_o  (lvl),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign unused_fall = fall;

  // The rise cycle is the first cycle of a new period, so the prescaler phase
  // restarts in that same cycle rather than one cycle later.
  logic [PW-1:0] pre_q, pre_d, pre_cur;
  logic          tick;

  always_comb begin
    pre_cur = rise ? '0 : pre_q;
    tick    = (pre_cur == PRE_MAX);
    pre_d   = tick ? '0 : pre_cur + 1'b1;
  end

  meas_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic             load_res, set_stall;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC: if (rise) state_d = MEAS;
      MEAS: if (!rise && cnt_q == SAT) state_d = SYNC;
    endcase
  end

  always_comb begin
    load_res  = (state_q == MEAS) && rise;
    set_stall = (state_q == MEAS) && !rise && (cnt_q == SAT);
  end

  // High count only advances alongside the tick count, so it can never exceed it.
  always_comb begin
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    if (rise) begin
      cnt_d  = CNT_W'(tick);
      hcnt_d = CNT_W'(tick & lvl);
    end else if (state_q == MEAS && tick && cnt_q != SAT) begin
      cnt_d = cnt_q + 1'b1;
      if (lvl) hcnt_d = hcnt_q + 1'b1;
    end
  end

  logic [CNT_W-1:0] period_q, high_q;
  logic             valid_q, lost_q, stall_q;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
      lost_q <= 1'b0;
      if (load_res) begin
        period_q <= cnt_q;
        high_q   <= hcnt_q;
        valid_q  <= 1'b1;
        lost_q   <= valid_q & ~res.ack_i;
      end else if (valid_q && res.ack_i) begin
        valid_q <= 1'b0;
      end
      if (set_stall) stall_q <= 1'b1;
      else if (rise) stall_q <= 1'b0;
    end
  end

  assign res.period_o = period_q;
  assign res.high_o   = high_q;
  assign res.valid_o  = valid_q;
  assign res.lost_o   = lost_q;
  assign res.stall_o  = stall_q;

endmodule

// File: tb/tb_led_rate_meas.sv
// Directed bench for led_rate_meas: a PRESCALE=4 instance for period/duty/handshake
// and a PRESCALE=1 instance for saturation and stall recovery.
module tb_led_rate_meas;

  logic clk = 1'b0;
  logic rst;
  logic led;

  always #5 clk = ~clk;

  led_rate_meas_if #(.CNT_W(12)) if4 ();
  led_rate_meas_if #(.CNT_W(12)) if1 ();

  led_rate_meas #(.PRESCALE(4), .CNT_W(12)) dut4 (
    .clk100 (clk),
    .rst    (rst),
    .led_i  (led),
    .res    (if4)
  );

  led_rate_meas #(.PRESCALE(1), .CNT_W(12)) dut1 (
    .clk100 (clk),
    .rst    (rst),
    .led_i  (led),
    .res    (if1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int hi;
    int lo;
    int exp_period;
    int exp_high;
  } vec_t;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{hi: 20, lo: 20, exp_period: 10, exp_high: 5};
    vecs[1] = '{hi: 20, lo: 20, exp_period: 10, exp_high: 5};
    vecs[2] = '{hi: 10, lo: 32, exp_period: 10, exp_high: 2};
    vecs[3] = '{hi: 7,  lo: 9,  exp_period: 4,  exp_high: 1};
    vecs[4] = '{hi: 5,  lo: 2,  exp_period: 1,  exp_high: 1};
    vecs[5] = '{hi: 13, lo: 3,  exp_period: 4,  exp_high: 3};
    vecs[6] = '{hi: 30, lo: 50, exp_period: 20, exp_high: 7};
    vecs[7] = '{hi: 8,  lo: 8,  exp_period: 4,  exp_high: 2};

    rst = 1'b1;
    led = 1'b0;
    if4.ack_i = 1'b1;
    if1.ack_i = 1'b1;
    cyc(3);
    chk("rst_period", if4.period_o, 0);
    chk("rst_high", if4.high_o, 0);
    chk("rst_valid", if4.valid_o, 0);
    chk("rst_lost", if4.lost_o, 0);
    chk("rst_stall", if4.stall_o, 0);
    rst = 1'b0;
    cyc(2);

    // Table: each rise closes the previous vector's period.
    for (int i = 0; i <= 8; i++) begin
      led = 1'b1;
      cyc(3);
      chk($sformatf("lat_n2[%0d]", i), if4.valid_o, 0);
      cyc(1);
      chk($sformatf("valid_n3[%0d]", i), if4.valid_o, (i > 0) ? 1 : 0);
      if (i > 0) begin
        chk($sformatf("period[%0d]", i - 1), if4.period_o, vecs[i - 1].exp_period);
        chk($sformatf("high[%0d]", i - 1), if4.high_o, vecs[i - 1].exp_high);
      end
      cyc(1);
      chk($sformatf("valid_pulse[%0d]", i), if4.valid_o, 0);
      if (i < 8) begin
        cyc(vecs[i].hi - 5);
        led = 1'b0;
        cyc(vecs[i].lo);
      end
    end

    // Lost result: two unacked results, then ack coinciding with a third.
    if4.ack_i = 1'b0;
    cyc(3);
    led = 1'b0;
    cyc(8);
    led = 1'b1;
    cyc(4);
    chk("lostA_valid", if4.valid_o, 1);
    chk("lostA_period", if4.period_o, 4);
    chk("lostA_high", if4.high_o, 2);
    chk("lostA_lost", if4.lost_o, 0);
    cyc(4);
    led = 1'b0;
    cyc(12);
    led = 1'b1;
    cyc(4);
    chk("lostB_valid", if4.valid_o, 1);
    chk("lostB_period", if4.period_o, 5);
    chk("lostB_high", if4.high_o, 2);
    chk("lostB_lost", if4.lost_o, 1);
    cyc(1);
    chk("lostB_pulse", if4.lost_o, 0);
    chk("lostB_hold", if4.valid_o, 1);
    cyc(3);
    led = 1'b0;
    cyc(4);
    led = 1'b1;
    cyc(3);
    if4.ack_i = 1'b1;
    cyc(1);
    chk("ackC_valid", if4.valid_o, 1);
    chk("ackC_lost", if4.lost_o, 0);
    chk("ackC_period", if4.period_o, 3);
    chk("ackC_high", if4.high_o, 2);
    cyc(1);
    chk("ackC_clear", if4.valid_o, 0);

    // Reset mid-measurement with a pending result.
    if4.ack_i = 1'b0;
    led = 1'b0;
    cyc(6);
    led = 1'b1;
    cyc(4);
    chk("preRst_valid", if4.valid_o, 1);
    chk("preRst_period", if4.period_o, 2);
    chk("preRst_high", if4.high_o, 1);
    cyc(4);
    rst = 1'b1;
    led = 1'b0;
    #1;
    chk("midRst_valid", if4.valid_o, 0);
    chk("midRst_period", if4.period_o, 0);
    chk("midRst_high", if4.high_o, 0);
    chk("midRst_lost", if4.lost_o, 0);
    chk("midRst_stall1", if1.stall_o, 0);
    chk("midRst_valid1", if1.valid_o, 0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    led = 1'b1;
    cyc(4);
    chk("postRst_arm4", if4.valid_o, 0);
    chk("postRst_arm1", if1.valid_o, 0);
    cyc(6);
    led = 1'b0;
    cyc(10);
    led = 1'b1;
    cyc(4);
    chk("postRst_valid4", if4.valid_o, 1);
    chk("postRst_period4", if4.period_o, 5);
    chk("postRst_high4", if4.high_o, 2);
    chk("postRst_valid1", if1.valid_o, 1);
    chk("postRst_period1", if1.period_o, 20);
    chk("postRst_high1", if1.high_o, 10);
    if4.ack_i = 1'b1;

    // Stall on the PRESCALE=1 instance: SAT ticks with no rise.
    led = 1'b0;
    cyc(4094);
    chk("stall_before", if1.stall_o, 0);
    cyc(1);
    chk("stall_set", if1.stall_o, 1);
    chk("stall_novalid", if1.valid_o, 0);
    chk("stall_4_quiet", if4.stall_o, 0);
    cyc(20);
    led = 1'b1;
    cyc(3);
    chk("stall_held", if1.stall_o, 1);
    cyc(1);
    chk("stall_clear", if1.stall_o, 0);
    chk("rearm_novalid", if1.valid_o, 0);
    cyc(4);
    led = 1'b0;
    cyc(7);
    led = 1'b1;
    cyc(4);
    chk("recov_valid", if1.valid_o, 1);
    chk("recov_period", if1.period_o, 15);
    chk("recov_high", if1.high_o, 8);
    chk("recov_stall", if1.stall_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
